// File: rtl/tmr_error_monitor.sv
// Error monitor for TMR voter mismatch lines: sticky mask, saturating count, alarm, clear handshake.
// Optional first-error capture enabled by defining TMR_ERR_FIRST_CAPTURE_EN.
module tmr_error_monitor #(
    parameter int N_ERR  = 8,
    parameter int CNT_W  = 16,
    parameter int THRESH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_ERR-1:0] err_in,
    input  logic             clr_req,
    output logic             clr_ack,
    output logic             err_any,
    output logic [N_ERR-1:0] err_sticky,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_sat,
    output logic             alarm
`ifdef TMR_ERR_FIRST_CAPTURE_EN
    ,
    output logic             first_valid,
    output logic [4:0]       first_idx,
    output logic [CNT_W-1:0] first_time
`endif
);

    localparam longint unsigned CntMax = (64'd1 << CNT_W) - 64'd1;
    localparam bit AlarmOn = (THRESH != 0);
    localparam logic [CNT_W-1:0] ThreshV = CNT_W'(THRESH);

    if (THRESH < 0 || 64'(THRESH) > CntMax) begin : gBadThresh
        $error("tmr_error_monitor: THRESH out of range for CNT_W");
    end

    if (N_ERR < 1 || N_ERR > 32) begin : gBadWidth
        $error("tmr_error_monitor: N_ERR must be 1..32");
    end

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        ACK,
        WAIT_REL
    } state_t;

    state_t           state;
    logic [N_ERR-1:0] errQ;
    logic             errHit;

    assign errHit  = |errQ;
    assign err_sat = &err_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            errQ       <= '0;
            err_any    <= 1'b0;
            err_sticky <= '0;
            err_cnt    <= '0;
            alarm      <= 1'b0;
            clr_ack    <= 1'b0;
        end else begin
            errQ       <= err_in;
            err_any    <= |err_in;
            clr_ack    <= 1'b0;
            alarm      <= AlarmOn && (err_cnt >= ThreshV);
            err_sticky <= err_sticky | errQ;
            if (errHit && !err_sat) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
            unique case (state)
                IDLE: begin
                    if (clr_req) state <= CLEAR;
                end
                CLEAR: begin
                    // an error seen during the clear becomes the first new event
                    err_cnt    <= CNT_W'(errHit);
                    err_sticky <= errQ;
                    alarm      <= 1'b0;
                    clr_ack    <= 1'b1;
                    state      <= ACK;
                end
                ACK: begin
                    state <= WAIT_REL;
                end
                WAIT_REL: begin
                    if (!clr_req) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TMR_ERR_FIRST_CAPTURE_EN
    function automatic logic [4:0] lowIdx(input logic [N_ERR-1:0] v);
        lowIdx = '0;
        for (int i = N_ERR - 1; i >= 0; i--) begin
            if (v[i]) lowIdx = 5'(i);
        end
    endfunction

    logic [CNT_W-1:0] tStamp;

    always_ff @(posedge clk) begin
        if (rst) begin
            tStamp      <= '0;
            first_valid <= 1'b0;
            first_idx   <= '0;
            first_time  <= '0;
        end else begin
            tStamp <= tStamp + CNT_W'(1);
            if (state == CLEAR) begin
                first_valid <= errHit;
                first_idx   <= errHit ? lowIdx(errQ) : 5'd0;
                first_time  <= errHit ? tStamp : '0;
            end else if (errHit && !first_valid) begin
                first_valid <= 1'b1;
                first_idx   <= lowIdx(errQ);
                first_time  <= tStamp;
            end
        end
    end
`endif

endmodule
